y86_pipe_chain: RTL and testbench
=================================

// Module: y86_pipe_chain
// PURPOSE
//  Parametrised chain of NSTAGES pipeline registers (default D,E,M,W) for the Y86-64 pipeline, with per-stage stall and bubble.
//  Each slot carries valid, stat, icode and a packed DATA_W payload; the fetch side feeds slot 0 and write-back reads the last slot.
//  Adds an exception freeze, control-conflict detection and performance counters that the per-stage register instances lack.
// PARAMETERS
//  NSTAGES  4   number of register slots (>=2); slot 0 = D, slot NSTAGES-1 = W
//  DATA_W   64  payload width per slot (valC/valA/valE/dst fields packed by the instantiator)
//  CNT_W    32  width of each performance counter
// PORTS
//  clk         in   1           clock, all state updates on posedge
//  rst         in   1           asynchronous reset, active-low
//  in_valid    in   1           slot-0 input holds a real instruction
//  in_stat     in   2           stat: 0=AOK 1=HLT 2=ADR 3=INS
//  in_icode    in   4           instruction code
//  in_data     in   DATA_W      payload
//  stall       in   NSTAGES     per-slot hold request, bit i = slot i
//  bubble      in   NSTAGES     per-slot NOP-insert request
//  slot_valid  out  NSTAGES     valid bit of every slot
//  slot_icode  out  4*NSTAGES   icodes, slot i at [4i+3:4i]
//  out_valid   out  1           last-slot valid
//  out_stat    out  2           last-slot stat
//  out_icode   out  4           last-slot icode
//  out_data    out  DATA_W      last-slot payload
//  halted      out  1           sticky: pipeline frozen on exception
//  ctrl_err    out  1           sticky: illegal stall/bubble combination seen
//  cyc_cnt     out  CNT_W       cycles since reset, excluding frozen cycles
//  ret_cnt     out  CNT_W       instructions retired with AOK
//  bub_cnt     out  CNT_W       bubbles inserted, all slots summed per cycle
// BEHAVIOUR
//  Reset (rst=0, async):
//  - every slot = NOP image: valid=0, stat=0, icode=4'h1, data=0
//  - halted=0, ctrl_err=0, all counters=0
//  - all outputs reflect these values while reset is held.
//  Slot update per posedge, slot i, src = inputs (i=0) or slot i-1:
//  - freeze=1: hold
//  - stall[i]=1: hold (stall beats bubble)
//  - bubble[i]=1: load NOP image
//  - otherwise: load src.
//  freeze = out_valid && out_stat!=0, combinational from the last slot.
//  - The faulting instruction stays in W indefinitely.
//  - halted sets on the first edge with freeze=1 and holds until reset.
//  - While frozen, inputs, stall and bubble are ignored.
//  ctrl_err sets on any edge (not frozen) where either:
//  - stall[i] && bubble[i], or
//  - stall[i-1] && !stall[i] && !bubble[i] for i>=1 (duplicated instruction).
//  Slot behaviour is unchanged by ctrl_err; it is a flag only.
//  Latency: an unstalled instruction reaches out_* NSTAGES edges after it is presented.
//  Counters, all not frozen, all saturate at all-ones (no wrap):
//  - cyc_cnt increments every edge.
//  - ret_cnt increments when out_valid && out_stat==0 && !stall[NSTAGES-1].
//  - bub_cnt adds popcount(bubble & ~stall).
//  A bubble into a slot is not a retire. A NOP image (valid=0) never counts as retired.
//  Reset mid-operation clears everything immediately, including an active freeze.
// TESTING
//  T1 reset: hold rst=0 with random inputs -> all slots valid=0 icode=1, halted=0, counters 0.
//  T2 flow: present icode=6 data=0x10 then NOPs, no stall/bubble -> out_icode=6 out_data=0x10 on edge 4; ret_cnt=1 after edge 5.
//  T3 load-use: stall[0]=1 bubble[1]=1 for one cycle -> slot0 holds, slot1 becomes NOP, bub_cnt+1, ctrl_err=0.
//  T4 conflict: stall[1]=1 bubble[1]=1 -> slot1 holds, ctrl_err=1; separately stall[0]=1 alone -> ctrl_err=1.
//  T5 halt: inject stat=1 icode=0 followed by valid AOK instructions -> HLT reaches W, halted=1, chain and counters frozen, ret_cnt excludes HLT.
//  T6 async reset: drop rst mid-T5 between clock edges -> outputs clear immediately without waiting for an edge; flow resumes as in T2.
//  T7 saturation: CNT_W=4, run 20 cycles -> cyc_cnt stays at 15.

Source files
------------

// File: rtl/y86_pipe_chain.sv
// Y86-64 pipeline register chain (D..W) with per-slot stall/bubble, exception freeze,
// stall/bubble conflict detection and saturating performance counters.

module y86_pipe_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              stall,
  input  logic              bubble,
  input  logic [DATA_W+6:0] src,
  output logic [DATA_W+6:0] q
);
  // {valid, stat, icode, data}; a bubble is an invalid AOK NOP
  localparam logic [DATA_W+6:0] NOP = {1'b0, 2'b00, 4'h1, {DATA_W{1'b0}}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   q <= NOP;
    else if (!(freeze || stall)) q <= bubble ? NOP : src;
  end
endmodule

module y86_pipe_chain #(
  parameter int NSTAGES = 4,
  parameter int DATA_W  = 64,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_stat,
  input  logic [3:0]           in_icode,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [NSTAGES-1:0]   stall,
  input  logic [NSTAGES-1:0]   bubble,
  output logic [NSTAGES-1:0]   slot_valid,
  output logic [4*NSTAGES-1:0] slot_icode,
  output logic                 out_valid,
  output logic [1:0]           out_stat,
  output logic [3:0]           out_icode,
  output logic [DATA_W-1:0]    out_data,
  output logic                 halted,
  output logic                 ctrl_err,
  output logic [CNT_W-1:0]     cyc_cnt,
  output logic [CNT_W-1:0]     ret_cnt,
  output logic [CNT_W-1:0]     bub_cnt
);
  localparam int SW   = DATA_W + 7;
  localparam int PC_W = $clog2(NSTAGES + 1);

  logic [NSTAGES-1:0][SW-1:0] slotQ, slotSrc;
  logic                       freeze, conflict;
  logic [NSTAGES-1:0]         bubEff;
  logic [PC_W-1:0]            bubPop;
  logic [CNT_W:0]             bubSum;

  assign slotSrc = {slotQ[NSTAGES-2:0], {in_valid, in_stat, in_icode, in_data}};

  genvar i;
  generate
    for (i = 0; i < NSTAGES; i++) begin : gSlot
      y86_pipe_slot #(.DATA_W(DATA_W)) uSlot (
        .clk(clk), .rst(rst), .freeze(freeze),
        .stall(stall[i]), .bubble(bubble[i]),
        .src(slotSrc[i]), .q(slotQ[i])
      );
      assign slot_valid[i]       = slotQ[i][SW-1];
      assign slot_icode[4*i +: 4] = slotQ[i][DATA_W +: 4];
    end
  endgenerate

  assign {out_valid, out_stat, out_icode, out_data} = slotQ[NSTAGES-1];
  // A faulting instruction parked in W stops the whole machine until reset
  assign freeze = out_valid && (out_stat != 2'd0);

  // Stalling a slot while its consumer neither stalls nor bubbles duplicates the instruction
  assign conflict = |(stall & bubble) |
                    |(stall[NSTAGES-2:0] & ~stall[NSTAGES-1:1] & ~bubble[NSTAGES-1:1]);

  assign bubEff = bubble & ~stall;
  always_comb begin
    bubPop = '0;
    for (int k = 0; k < NSTAGES; k++) bubPop = bubPop + PC_W'(bubEff[k]);
  end
  assign bubSum = {1'b0, bub_cnt} + (CNT_W+1)'(bubPop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted   <= 1'b0;
      ctrl_err <= 1'b0;
      cyc_cnt  <= '0;
      ret_cnt  <= '0;
      bub_cnt  <= '0;
    end else if (freeze) begin
      halted <= 1'b1;
    end else begin
      if (conflict) ctrl_err <= 1'b1;
      if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (out_valid && out_stat == 2'd0 && !stall[NSTAGES-1] && ret_cnt != '1)
        ret_cnt <= ret_cnt + CNT_W'(1);
      bub_cnt <= bubSum[CNT_W] ? '1 : bubSum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_y86_pipe_chain.sv
// Directed + randomized bench for y86_pipe_chain against a slot-array reference model.

module tb_y86_pipe_chain;
  localparam int N  = 4;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          inValid;
  logic [1:0]    inStat;
  logic [3:0]    inIcode;
  logic [DW-1:0] inData;
  logic [N-1:0]  stall, bubble;

  logic [N-1:0]   slotValid, sSlotValid;
  logic [4*N-1:0] slotIcode, sSlotIcode;
  logic           outValid, sOutValid;
  logic [1:0]     outStat, sOutStat;
  logic [3:0]     outIcode, sOutIcode;
  logic [DW-1:0]  outData, sOutData;
  logic           halted, ctrlErr, sHalted, sCtrlErr;
  logic [31:0]    cycCnt, retCnt, bubCnt;
  logic [3:0]     sCyc, sRet, sBub;

  y86_pipe_chain #(.NSTAGES(N), .DATA_W(DW), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_stat(inStat), .in_icode(inIcode),
    .in_data(inData), .stall(stall), .bubble(bubble), .slot_valid(slotValid),
    .slot_icode(slotIcode), .out_valid(outValid), .out_stat(outStat), .out_icode(outIcode),
    .out_data(outData), .halted(halted), .ctrl_err(ctrlErr), .cyc_cnt(cycCnt),
    .ret_cnt(retCnt), .bub_cnt(bubCnt)
  );

  y86_pipe_chain #(.NSTAGES(N), .DATA_W(DW), .CNT_W(4)) dutSmall (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_stat(inStat), .in_icode(inIcode),
    .in_data(inData), .stall(stall), .bubble(bubble), .slot_valid(sSlotValid),
    .slot_icode(sSlotIcode), .out_valid(sOutValid), .out_stat(sOutStat), .out_icode(sOutIcode),
    .out_data(sOutData), .halted(sHalted), .ctrl_err(sCtrlErr), .cyc_cnt(sCyc),
    .ret_cnt(sRet), .bub_cnt(sBub)
  );

  // Reference model: one record per slot, plain integer counters
  bit          mV[N];
  logic [1:0]  mS[N];
  logic [3:0]  mI[N];
  logic [63:0] mD[N];
  bit          mHalt, mErr;
  int          mCyc, mRet, mBub;
  int          nCmp = 0, nErr = 0;

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin mV[i] = 0; mS[i] = 0; mI[i] = 4'h1; mD[i] = '0; end
    mHalt = 0; mErr = 0; mCyc = 0; mRet = 0; mBub = 0;
  endfunction

  function automatic void modelStep();
    if (mV[N-1] && mS[N-1] != 0) begin mHalt = 1; return; end
    for (int i = 0; i < N; i++) begin
      if (stall[i] && bubble[i]) mErr = 1;
      if (i > 0 && stall[i-1] && !stall[i] && !bubble[i]) mErr = 1;
      if (bubble[i] && !stall[i]) mBub++;
    end
    mCyc++;
    if (mV[N-1] && mS[N-1] == 0 && !stall[N-1]) mRet++;
    for (int i = N-1; i >= 0; i--) begin
      if (stall[i]) continue;
      if (bubble[i]) begin mV[i] = 0; mS[i] = 0; mI[i] = 4'h1; mD[i] = '0; end
      else if (i == 0) begin mV[0] = inValid; mS[0] = inStat; mI[0] = inIcode; mD[0] = inData; end
      else begin mV[i] = mV[i-1]; mS[i] = mS[i-1]; mI[i] = mI[i-1]; mD[i] = mD[i-1]; end
    end
  endfunction

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [N-1:0]   ev;
    logic [4*N-1:0] ei;
    for (int i = 0; i < N; i++) begin ev[i] = mV[i]; ei[4*i +: 4] = mI[i]; end
    chk("slot_valid", slotValid, ev);
    chk("slot_icode", slotIcode, ei);
    chk("out_valid", outValid, mV[N-1]);
    chk("out_stat", outStat, mS[N-1]);
    chk("out_icode", outIcode, mI[N-1]);
    chk("out_data", outData, mD[N-1]);
    chk("halted", halted, mHalt);
    chk("ctrl_err", ctrlErr, mErr);
    chk("cyc_cnt", cycCnt, mCyc);
    chk("ret_cnt", retCnt, mRet);
    chk("bub_cnt", bubCnt, mBub);
    chk("small_cyc", sCyc, sat4(mCyc));
    chk("small_ret", sRet, sat4(mRet));
    chk("small_bub", sBub, sat4(mBub));
  endtask

  task automatic setNop();
    inValid = 0; inStat = 0; inIcode = 4'h1; inData = '0; stall = '0; bubble = '0;
  endtask

  task automatic setInstr(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] d);
    inValid = 1; inStat = st; inIcode = ic; inData = d;
  endtask

  task automatic randInputs();
    inValid = 1'($urandom);
    inStat  = ($urandom_range(49) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
    inIcode = 4'($urandom);
    inData  = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      stall[i]  = ($urandom_range(7) == 0);
      bubble[i] = ($urandom_range(7) == 0);
    end
  endtask

  task automatic step();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge
  task automatic doReset();
    #2;
    rst = 0;
    modelReset();
    #1;
    checkAll();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic flowT2(input string tag);
    setNop();
    setInstr(2'd0, 4'h6, 64'h10);
    step();
    setNop();
    repeat (3) step();
    chk({tag, " out_icode"}, outIcode, 4'h6);
    chk({tag, " out_data"}, outData, 64'h10);
    chk({tag, " out_valid"}, outValid, 1'b1);
    step();
    chk({tag, " ret_cnt"}, retCnt, 32'd1);
  endtask

  initial begin
    int b0;
    // T1: reset held with random inputs across edges
    rst = 0;
    modelReset();
    repeat (3) begin
      randInputs();
      @(posedge clk);
      #1;
      checkAll();
    end
    chk("T1 valid", slotValid, 4'h0);
    chk("T1 icode", slotIcode, 16'h1111);
    chk("T1 cyc", cycCnt, 32'd0);
    @(negedge clk);
    rst = 1;

    // T2: single instruction flows to W in NSTAGES edges
    flowT2("T2");

    // T3: load-use stall of D with bubble into E
    setInstr(2'd0, 4'h2, 64'h20); step();
    setInstr(2'd0, 4'h3, 64'h30); step();
    setInstr(2'd0, 4'h4, 64'h40);
    stall = 4'b0001; bubble = 4'b0010;
    b0 = mBub;
    step();
    chk("T3 slot0 hold", slotIcode[3:0], 4'h3);
    chk("T3 slot1 nop", slotValid[1], 1'b0);
    chk("T3 slot1 icode", slotIcode[7:4], 4'h1);
    chk("T3 bub", bubCnt, 32'(b0 + 1));
    chk("T3 ctrl_err", ctrlErr, 1'b0);

    // T4: stall+bubble on the same slot, then stall of D alone
    stall = 4'b0010; bubble = 4'b0010;
    step();
    chk("T4a ctrl_err", ctrlErr, 1'b1);
    doReset();
    setNop();
    stall = 4'b0001;
    step();
    chk("T4b ctrl_err", ctrlErr, 1'b1);
    doReset();

    // T5: HLT reaches W and freezes everything
    setNop();
    setInstr(2'd0, 4'h2, 64'hA); step();
    setInstr(2'd0, 4'h3, 64'hB); step();
    setInstr(2'd1, 4'h0, 64'hC); step();
    setInstr(2'd0, 4'h5, 64'hD);
    repeat (3) step();
    chk("T5 out_stat", outStat, 2'd1);
    repeat (3) begin randInputs(); step(); end
    chk("T5 halted", halted, 1'b1);
    chk("T5 out_icode", outIcode, 4'h0);
    chk("T5 cyc", cycCnt, 32'd6);
    chk("T5 ret", retCnt, 32'd2);

    // T6: async reset while frozen, then normal flow again
    doReset();
    chk("T6 halted", halted, 1'b0);
    chk("T6 out_valid", outValid, 1'b0);
    flowT2("T6");

    // T7: 4-bit counters saturate
    doReset();
    setNop();
    repeat (20) step();
    chk("T7 small cyc", sCyc, 4'hF);
    chk("T7 cyc", cycCnt, 32'd20);

    // Randomized traffic with occasional exceptions and resets
    for (int n = 0; n < 400; n++) begin
      randInputs();
      step();
      if ((mHalt && $urandom_range(3) == 0) || $urandom_range(99) == 0) doReset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
